// File: rtl/bram_be_arbiter.sv
// bram_be_arbiter: shares one dual-port byte-enable block RAM
// (1 read port, 1 write port, 1-cycle registered read) between
// NUM_CLIENTS requesters. Reads and writes have independent
// round-robin arbiters. A read that would hit the address being
// written in the same cycle is held off for that cycle.
//
// Ports:
//   CLK, RST        clock (rising), async active-high reset
//   RD_REQ_VALID/ADDR/READY   per-client read request, 1-hot grant
//   RD_RESP_VALID/DATA        1-hot response strobe, shared data
//   WR_REQ_VALID/ADDR/DATA/BE/READY  per-client write, 1-hot grant
//   RAM_RD_ADDR/RE, RAM_WR_ADDR/DI/WE/BE, RAM_DO  block RAM side
//   STALL_COUNT     saturating collision-stall counter, present
//                   only when BRAM_ARB_STATS_EN is defined
module bram_be_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int BE_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NUM_CLIENTS-1:0]            RD_REQ_VALID,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] RD_REQ_ADDR,
  output logic [NUM_CLIENTS-1:0]            RD_REQ_READY,
  output logic [NUM_CLIENTS-1:0]            RD_RESP_VALID,
  output logic [DATA_WIDTH-1:0]             RD_RESP_DATA,
  input  logic [NUM_CLIENTS-1:0]            WR_REQ_VALID,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] WR_REQ_ADDR,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] WR_REQ_DATA,
  input  logic [NUM_CLIENTS*BE_WIDTH-1:0]   WR_REQ_BE,
  output logic [NUM_CLIENTS-1:0]            WR_REQ_READY,
  output logic [ADDR_WIDTH-1:0]             RAM_RD_ADDR,
  output logic                              RAM_RE,
  output logic [ADDR_WIDTH-1:0]             RAM_WR_ADDR,
  output logic [DATA_WIDTH-1:0]             RAM_DI,
  output logic                              RAM_WE,
  output logic [BE_WIDTH-1:0]               RAM_BE,
  input  logic [DATA_WIDTH-1:0]             RAM_DO
`ifdef BRAM_ARB_STATS_EN
  ,
  output logic [15:0]                       STALL_COUNT
`endif
);

  localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef logic [PW-1:0] idx_t;

  localparam logic [NUM_CLIENTS-1:0] ONE = NUM_CLIENTS'(1);
  localparam idx_t LAST = idx_t'(NUM_CLIENTS - 1);

  // Round-robin pick. Walking from the farthest slot back to the
  // nearest lets the nearest valid requester overwrite the result,
  // so the first valid client after `last` wins without a break.
  // Result is {found, index}.
  function automatic logic [PW:0] rr_pick(
    input logic [NUM_CLIENTS-1:0] req,
    input idx_t                   last
  );
    logic [PW:0] res;
    int          idx;
    idx_t        sel;
    res = '0;
    for (int k = NUM_CLIENTS; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      sel = idx_t'(idx);
      if (req[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  idx_t                   wptr_q, wptr_d;
  idx_t                   rptr_q, rptr_d;
  logic [NUM_CLIENTS-1:0] resp_sel_q, resp_sel_d;

  logic [PW:0]            wpick;
  logic [PW:0]            rpick;
  logic                   wr_go;
  idx_t                   wr_idx;
  logic                   rd_cand;
  idx_t                   rd_idx;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic                   collision;
  logic                   rd_go;

  // Arbitration. Nothing is granted while reset is asserted.
  always_comb begin
    wpick   = rr_pick(WR_REQ_VALID, wptr_q);
    rpick   = rr_pick(RD_REQ_VALID, rptr_q);
    wr_go   = wpick[PW] & ~RST;
    wr_idx  = wpick[PW-1:0];
    rd_cand = rpick[PW] & ~RST;
    rd_idx  = rpick[PW-1:0];
  end

  // Payload muxes, selected by winner index.
  always_comb begin
    wr_addr = WR_REQ_ADDR[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    rd_addr = RD_REQ_ADDR[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    RAM_DI  = WR_REQ_DATA[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
    RAM_BE  = WR_REQ_BE[int'(wr_idx)*BE_WIDTH +: BE_WIDTH];
  end

  // The RAM gives undefined read data when both ports hit the same
  // address in one cycle; the write wins and the read waits.
  assign collision = wr_go & rd_cand & (rd_addr == wr_addr);
  assign rd_go     = rd_cand & ~collision;

  assign RAM_WE      = wr_go;
  assign RAM_WR_ADDR = wr_addr;
  assign RAM_RE      = rd_go;
  assign RAM_RD_ADDR = rd_addr;

  assign WR_REQ_READY = wr_go ? (ONE << wr_idx) : '0;
  assign RD_REQ_READY = rd_go ? (ONE << rd_idx) : '0;

  always_comb begin
    wptr_d     = wr_go ? wr_idx : wptr_q;
    rptr_d     = rd_go ? rd_idx : rptr_q;
    resp_sel_d = RD_REQ_READY;
  end

  // Pointers reset to the last index so client 0 is searched first.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_q     <= LAST;
      rptr_q     <= LAST;
      resp_sel_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      resp_sel_q <= resp_sel_d;
    end
  end

  // Response strobe follows the grant by the RAM's read latency;
  // data is the RAM output as-is, shared by all clients.
  assign RD_RESP_VALID = resp_sel_q;
  assign RD_RESP_DATA  = RAM_DO;

`ifdef BRAM_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (collision && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign STALL_COUNT = stall_q;
`endif

endmodule

// File: tb/tb_bram_be_arbiter.sv
// tb_bram_be_arbiter: directed plan scenarios plus randomized
// traffic, checked against a behavioural model with shadow memory.
module tb_bram_be_arbiter;

  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [N-1:0]  rd_v, wr_v;
  logic [AW-1:0] rd_a  [N];
  logic [AW-1:0] wr_a  [N];
  logic [DW-1:0] wr_d  [N];
  logic [BW-1:0] wr_be [N];

  logic [N*AW-1:0] rd_a_bus, wr_a_bus;
  logic [N*DW-1:0] wr_d_bus;
  logic [N*BW-1:0] wr_be_bus;

  always_comb begin
    rd_a_bus  = '0;
    wr_a_bus  = '0;
    wr_d_bus  = '0;
    wr_be_bus = '0;
    for (int i = 0; i < N; i++) begin
      rd_a_bus[i*AW +: AW]  = rd_a[i];
      wr_a_bus[i*AW +: AW]  = wr_a[i];
      wr_d_bus[i*DW +: DW]  = wr_d[i];
      wr_be_bus[i*BW +: BW] = wr_be[i];
    end
  end

  logic [N-1:0]  rd_rdy, rd_rv, wr_rdy;
  logic [DW-1:0] rd_rd;
  logic [AW-1:0] ram_ra, ram_wa;
  logic          ram_re, ram_we;
  logic [DW-1:0] ram_di, ram_do;
  logic [BW-1:0] ram_be;
`ifdef BRAM_ARB_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  bram_be_arbiter #(
    .NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .RD_REQ_VALID(rd_v), .RD_REQ_ADDR(rd_a_bus),
    .RD_REQ_READY(rd_rdy),
    .RD_RESP_VALID(rd_rv), .RD_RESP_DATA(rd_rd),
    .WR_REQ_VALID(wr_v), .WR_REQ_ADDR(wr_a_bus),
    .WR_REQ_DATA(wr_d_bus), .WR_REQ_BE(wr_be_bus),
    .WR_REQ_READY(wr_rdy),
    .RAM_RD_ADDR(ram_ra), .RAM_RE(ram_re),
    .RAM_WR_ADDR(ram_wa), .RAM_DI(ram_di),
    .RAM_WE(ram_we), .RAM_BE(ram_be),
    .RAM_DO(ram_do)
`ifdef BRAM_ARB_STATS_EN
    , .STALL_COUNT(stall_cnt)
`endif
  );

  function automatic logic [DW-1:0] init_word(input int a);
    return (32'(a) * 32'h01030507) ^ 32'h5A5A0000;
  endfunction

  // Block RAM: byte-enable write, registered read.
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] ram_q;
  assign ram_do = ram_q;

  always @(posedge CLK) begin
    if (ram_we)
      for (int b = 0; b < BW; b++)
        if (ram_be[b]) mem[ram_wa][b*8 +: 8] <= ram_di[b*8 +: 8];
    if (ram_re) ram_q <= mem[ram_ra];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  int            wptr = N - 1;
  int            rptr = N - 1;
  logic [DW-1:0] shadow [1<<AW];
  logic [N-1:0]  exp_rv = '0;
  logic [DW-1:0] exp_rd = '0;
  int            stall = 0;
  logic [N-1:0]  last_wg = '0;
  logic [N-1:0]  last_rg = '0;

  // Called just after the negedge where inputs were driven.
  // Checks this cycle, advances the model at the posedge, and
  // returns at the following negedge.
  task automatic cyc();
    logic [N-1:0] ew, er;
    int           wi, ri, ix;
    bit           wf, rf, col;
    #1;
    ew = '0; er = '0; wi = 0; ri = 0;
    wf = 0; rf = 0; col = 0;
    if (RST) begin
      exp_rv = '0;
      stall  = 0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        ix = (wptr + k) % N;
        if (!wf && wr_v[ix]) begin wf = 1; wi = ix; end
      end
      for (int k = 1; k <= N; k++) begin
        ix = (rptr + k) % N;
        if (!rf && rd_v[ix]) begin rf = 1; ri = ix; end
      end
      col = wf && rf && (rd_a[ri] == wr_a[wi]);
      if (wf) ew[wi] = 1'b1;
      if (rf && !col) er[ri] = 1'b1;
    end
    chk("wr_ready", wr_rdy, ew);
    chk("rd_ready", rd_rdy, er);
    chk("ram_we", ram_we, wf);
    chk("ram_re", ram_re, |er);
    if (wf) begin
      chk("ram_wa", ram_wa, wr_a[wi]);
      chk("ram_di", ram_di, wr_d[wi]);
      chk("ram_be", ram_be, wr_be[wi]);
    end
    if (|er) chk("ram_ra", ram_ra, rd_a[ri]);
    chk("resp_v", rd_rv, exp_rv);
    if (exp_rv != '0) chk("resp_d", rd_rd, exp_rd);
`ifdef BRAM_ARB_STATS_EN
    chk("stall_cnt", stall_cnt, 64'(stall));
`endif
    @(posedge CLK);
    if (RST) begin
      wptr   = N - 1;
      rptr   = N - 1;
      exp_rv = '0;
      stall  = 0;
    end else begin
      if (wf) wptr = wi;
      if (|er) begin
        rptr   = ri;
        exp_rd = shadow[rd_a[ri]];
      end
      exp_rv = er;
      if (col && stall < 16'hFFFF) stall++;
      if (wf)
        for (int b = 0; b < BW; b++)
          if (wr_be[wi][b]) shadow[wr_a[wi]][b*8 +: 8] = wr_d[wi][b*8 +: 8];
    end
    last_wg = ew;
    last_rg = er;
    @(negedge CLK);
  endtask

  task automatic idle();
    rd_v = '0;
    wr_v = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] old9;
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a]    = init_word(a);
      shadow[a] = init_word(a);
    end
    for (int i = 0; i < N; i++) begin
      rd_a[i] = '0; wr_a[i] = '0; wr_d[i] = '0; wr_be[i] = '0;
    end
    idle();
    RST = 1'b1;
    @(negedge CLK);
    repeat (3) cyc();

    // 1: idle after reset release
    RST = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("t1_idle", {wr_rdy, rd_rdy, rd_rv, ram_we, ram_re}, '0);
    end

    // 2: write then read same address from another client
    wr_v = 2'b01; wr_a[0] = 10'd5;
    wr_d[0] = 32'hAABBCCDD; wr_be[0] = 4'hF;
    cyc();
    chk("t2_wgrant", last_wg, 2'b01);
    idle();
    rd_v = 2'b10; rd_a[1] = 10'd5;
    cyc();
    chk("t2_rgrant", last_rg, 2'b10);
    idle();
    chk("t2_resp_v", rd_rv, 2'b10);
    chk("t2_resp_d", rd_rd, 32'hAABBCCDD);

    // 3: continuous contention alternates
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    wr_v = 2'b11; rd_v = 2'b11;
    wr_a[0] = 10'd100; wr_a[1] = 10'd101;
    wr_d[0] = 32'h11111111; wr_d[1] = 32'h22222222;
    wr_be[0] = 4'hF; wr_be[1] = 4'hF;
    rd_a[0] = 10'd200; rd_a[1] = 10'd201;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("t3_wr", last_wg, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("t3_rd", last_rg, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    idle();

    // 4: same-cycle write/read to addr 9 stalls the read
    old9 = init_word(9);
    wr_v = 2'b01; wr_a[0] = 10'd9;
    wr_be[0] = 4'b0011; wr_d[0] = 32'h00001234;
    rd_v = 2'b10; rd_a[1] = 10'd9;
    cyc();
    chk("t4_wr", last_wg, 2'b01);
    chk("t4_stall", last_rg, 2'b00);
`ifdef BRAM_ARB_STATS_EN
    chk("t4_cnt", stall_cnt, 16'd1);
`endif
    wr_v = 2'b00;
    cyc();
    chk("t4_grant", last_rg, 2'b10);
    idle();
    chk("t4_resp_v", rd_rv, 2'b10);
    chk("t4_resp_d", rd_rd, {old9[31:16], 16'h1234});

    // 5: different addresses both granted
    wr_v = 2'b01; wr_a[0] = 10'd3;
    wr_d[0] = 32'hCAFEF00D; wr_be[0] = 4'hF;
    rd_v = 2'b10; rd_a[1] = 10'd4;
    cyc();
    chk("t5_wr", last_wg, 2'b01);
    chk("t5_rd", last_rg, 2'b10);
    idle();
    chk("t5_resp_v", rd_rv, 2'b10);
    chk("t5_resp_d", rd_rd, init_word(4));

    // 6: reset right after a read grant drops the response
    rd_v = 2'b01; rd_a[0] = 10'd7;
    cyc();
    chk("t6_grant", last_rg, 2'b01);
    idle();
    RST = 1'b1;
    cyc();
    chk("t6_rv_rst", rd_rv, 2'b00);
    RST = 1'b0;
    cyc();
    chk("t6_rv_after", rd_rv, 2'b00);
    wr_v = 2'b11; rd_v = 2'b11;
    wr_a[0] = 10'd20; wr_a[1] = 10'd21;
    rd_a[0] = 10'd30; rd_a[1] = 10'd31;
    cyc();
    chk("t6_wr_first", last_wg, 2'b01);
    chk("t6_rd_first", last_rg, 2'b01);
    idle();
    cyc();

    // Randomized traffic over a small address window so that
    // collisions are frequent; requests held until granted.
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < N; i++) begin
        if (last_wg[i] || !wr_v[i]) begin
          if ($urandom_range(0, 99) < 60) begin
            wr_v[i]  = 1'b1;
            wr_a[i]  = AW'($urandom_range(0, 7));
            wr_d[i]  = $urandom;
            wr_be[i] = BW'($urandom);
          end else begin
            wr_v[i] = 1'b0;
          end
        end
        if (last_rg[i] || !rd_v[i]) begin
          if ($urandom_range(0, 99) < 60) begin
            rd_v[i] = 1'b1;
            rd_a[i] = AW'($urandom_range(0, 7));
          end else begin
            rd_v[i] = 1'b0;
          end
        end
      end
      cyc();
    end
    RST = 1'b0;
    idle();
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
